popcount_arbiter: RTL and testbench



---
 rtl/popcount_arbiter_pkg.sv | 32 +++
 rtl/popcount64.sv | 24 ++
 rtl/popcount_arbiter_rr_pick.sv | 33 +++
 rtl/popcount_arbiter.sv | 121 ++++++++++++
 tb/tb_popcount_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/popcount_arbiter_pkg.sv
// Purpose: shared widths, constants and tagged-result types for popcount_arbiter.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package popcount_arbiter_pkg;

  localparam int BB_W    = 64;  // bitboard width
  localparam int CNT_W   = 6;   // raw popcount width (wraps 64 -> 0)
  localparam int POP_W   = 7;   // corrected population width (0..64)
  localparam int ID_MAXW = 4;   // widest requester index carried in the shadow pipe

  localparam logic [BB_W-1:0] BB_FULL = 64'hFFFF_FFFF_FFFF_FFFF;

  // Sideband travelling alongside the popcount datapath.
  typedef struct packed {
    logic               valid;
    logic [ID_MAXW-1:0] id;
    logic               full;
  } shadow_t;

  // Tagged result presented to the requesters.
  typedef struct packed {
    logic               valid;
    logic [ID_MAXW-1:0] id;
    logic [POP_W-1:0]   pop;
  } tag_res_t;

  // The 6-bit counter reads 0 for a full board; the shadow full flag restores 64.
  function automatic logic [POP_W-1:0] fix_pop(input logic full, input logic [CNT_W-1:0] pc);
    return full ? 7'd64 : {1'b0, pc};
  endfunction

endpackage

// File: rtl/popcount64.sv
// Purpose: 64-bit population count, 6-bit result (a full board wraps to 0).
// Latency: 1 cycle, registered output, no reset.
// Backpressure: none; accepts a new bitboard every cycle.
// Ports: clk, bb (bitboard in), pc_out (registered 6-bit count).
module popcount64 (
  input  logic        clk,
  input  logic [63:0] bb,
  output logic [5:0]  pc_out
);

  logic [5:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < 64; i++) begin
      sum = sum + 6'(bb[i]);
    end
  end

  always_ff @(posedge clk) begin
    pc_out <= sum;
  end

endmodule

// File: rtl/popcount_arbiter_rr_pick.sv
// Purpose: round-robin picker; first asserted request at or after rr_ptr, modulo NREQ.
// Latency: combinational.
// Backpressure: n/a; grant is one-hot or zero.
// Ports: req (requests), rr_ptr (highest-priority index), grant (one-hot), winner (index), any (a grant exists).
module popcount_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  winner,
  output logic            any
);

  int idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        winner     = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/popcount_arbiter.sv
// Purpose: round-robin share of one 64-bit popcount among NREQ requesters, tagged 7-bit result.
// Latency: result 1 cycle after the granting edge, 2 cycles with POPCOUNT_ARB_PIPE_EN defined.
// Backpressure: none on results; req is held until grant, one bitboard accepted per cycle.
// Ports: clk, reset (sync, active-high), req/req_bb (requests, bitboard i at [i*64+:64]),
//        grant (one-hot, combinational), result_valid (one-hot pulse), result_id, population.
// Build option: POPCOUNT_ARB_PIPE_EN adds an input register stage ahead of the popcount.
module popcount_arbiter
  import popcount_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*BB_W-1:0] req_bb,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      result_valid,
  output logic [IDW-1:0]       result_id,
  output logic [POP_W-1:0]     population
);

  logic [IDW-1:0]   rr_ptr;
  logic [NREQ-1:0]  pick_grant;
  logic [IDW-1:0]   winner;
  logic             pick_any;
  logic             gnt_any;
  logic [BB_W-1:0]  sel_bb;
  logic [BB_W-1:0]  pc_in;
  logic [CNT_W-1:0] pc_out;
  shadow_t          sh_in;
  shadow_t          sh_src;
  shadow_t          sh_d;
  tag_res_t         res;

  popcount_arbiter_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .grant  (pick_grant),
    .winner (winner),
    .any    (pick_any)
  );

  assign grant   = reset ? '0 : pick_grant;
  assign gnt_any = pick_any & ~reset;

  // Zero when nothing is granted, so idle cycles and reset push an empty board.
  always_comb begin
    sel_bb = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) sel_bb = req_bb[i*BB_W +: BB_W];
    end
  end

  always_comb begin
    sh_in       = '0;
    sh_in.valid = gnt_any;
    sh_in.id    = ID_MAXW'(winner);
    sh_in.full  = gnt_any && (sel_bb == BB_FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (gnt_any) begin
      rr_ptr <= (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
    end
  end

`ifdef POPCOUNT_ARB_PIPE_EN
  shadow_t         sh_p;
  logic [BB_W-1:0] bb_p;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_p <= '0;
      bb_p <= '0;
    end else begin
      sh_p <= sh_in;
      bb_p <= sel_bb;
    end
  end

  // Force an empty board through during reset so population reads 0 afterwards.
  assign pc_in  = reset ? '0 : bb_p;
  assign sh_src = sh_p;
`else
  assign pc_in  = sel_bb;
  assign sh_src = sh_in;
`endif

  popcount64 u_pc (
    .clk    (clk),
    .bb     (pc_in),
    .pc_out (pc_out)
  );

  always_ff @(posedge clk) begin
    if (reset) sh_d <= '0;
    else       sh_d <= sh_src;
  end

  // Outputs read zero while reset is high, so a result granted just before reset never pulses.
  always_comb begin
    res       = '0;
    res.valid = sh_d.valid & ~reset;
    res.id    = reset ? '0 : sh_d.id;
    res.pop   = reset ? '0 : fix_pop(sh_d.full, pc_out);
  end

  always_comb begin
    result_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (res.valid && res.id == ID_MAXW'(i)) result_valid[i] = 1'b1;
    end
  end

  assign result_id  = IDW'(res.id);
  assign population = res.pop;

endmodule

// File: tb/tb_popcount_arbiter.sv
module tb_popcount_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 3;
`ifdef POPCOUNT_ARB_PIPE_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*64-1:0] req_bb = '0;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   result_valid;
  logic [IDW-1:0]    result_id;
  logic [6:0]        population;

  always #5 clk = ~clk;

  popcount_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_bb       (req_bb),
    .grant        (grant),
    .result_valid (result_valid),
    .result_id    (result_id),
    .population   (population)
  );

  int nchk  = 0;
  int npass = 0;

  // Reference model: pointer, expected grant, and a result delay line of length L.
  int              mptr = 0;
  int              ep_v   [1:L];
  int              ep_id  [1:L];
  int              ep_pop [1:L];
  int              cur_v, cur_id, cur_pop;
  logic [NREQ-1:0] ex_grant;
  logic [NREQ-1:0] ex_rv = '0;
  int              ex_id, ex_pop;
  int              nres;

  function automatic int count_ones(input logic [63:0] b);
    int n = 0;
    for (int i = 0; i < 64; i++) if (b[i]) n++;
    return n;
  endfunction

  task automatic predict();
    ex_grant = '0;
    cur_v = 0; cur_id = 0; cur_pop = 0;
    if (!reset) begin
      for (int k = 0; k < NREQ; k++) begin
        int i = (mptr + k) % NREQ;
        if (cur_v == 0 && req[i]) begin
          cur_v = 1;
          cur_id = i;
          cur_pop = count_ones(req_bb[i*64 +: 64]);
          ex_grant[i] = 1'b1;
        end
      end
    end
  endtask

  // Advance one clock; outputs settle by the time this returns.
  task automatic tick();
    logic rst_at_edge;
    predict();
    rst_at_edge = reset;
    @(posedge clk);
    if (rst_at_edge) begin
      mptr = 0;
      for (int k = 1; k <= L; k++) begin ep_v[k] = 0; ep_id[k] = 0; ep_pop[k] = 0; end
    end else begin
      for (int k = L; k >= 2; k--) begin
        ep_v[k] = ep_v[k-1]; ep_id[k] = ep_id[k-1]; ep_pop[k] = ep_pop[k-1];
      end
      ep_v[1] = cur_v; ep_id[1] = cur_id; ep_pop[1] = cur_pop;
      if (cur_v != 0) mptr = (cur_id + 1) % NREQ;
    end
    ex_rv = '0;
    if (ep_v[L] != 0) ex_rv[ep_id[L]] = 1'b1;
    ex_id  = ep_id[L];
    ex_pop = ep_pop[L];
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = '1;
    req_bb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    #1;
    nchk++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b expected 0000", grant); else npass++;
    tick();
    tick();
    reset = 1'b0;
    req = '0;
    #1;
    nchk++; if (result_valid !== 4'b0000) $display("FAIL reset_rv: got %b expected 0000", result_valid); else npass++;
    nchk++; if (result_id !== 3'd0) $display("FAIL reset_id: got %0d expected 0", result_id); else npass++;
    nchk++; if (population !== 7'd0) $display("FAIL reset_pop: got %0d expected 0", population); else npass++;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    req_bb[2*64 +: 64] = 64'h0000_0000_0000_00FF;
    #1;
    nchk++; if (grant !== 4'b0100) $display("FAIL single_grant: got %b expected 0100", grant); else npass++;
    tick();
    req = '0;
    for (int c = 1; c < L; c++) begin
      nchk++; if (result_valid !== 4'b0000) $display("FAIL single_early: got %b expected 0000", result_valid); else npass++;
      tick();
    end
    nchk++; if (result_valid !== 4'b0100) $display("FAIL single_rv: got %b expected 0100", result_valid); else npass++;
    nchk++; if (result_id !== 3'd2) $display("FAIL single_id: got %0d expected 2", result_id); else npass++;
    nchk++; if (population !== 7'd8) $display("FAIL single_pop: got %0d expected 8", population); else npass++;
    tick();
    nchk++; if (result_valid !== 4'b0000) $display("FAIL single_pulse: got %b expected 0000", result_valid); else npass++;
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] exp_g;
    do_reset();
    for (int i = 0; i < NREQ; i++) req_bb[i*64 +: 64] = {$urandom, $urandom};
    req = '1;
    nres = 0;
    for (int c = 0; c < 8 + L; c++) begin
      if (c == 8) req = '0;
      #1;
      predict();
      exp_g = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
      nchk++; if (grant !== exp_g) $display("FAIL fair_grant[%0d]: got %b expected %b", c, grant, exp_g); else npass++;
      tick();
      nchk++; if (result_valid !== ex_rv) $display("FAIL fair_rv[%0d]: got %b expected %b", c, result_valid, ex_rv); else npass++;
      if (ex_rv != 0) begin
        nres++;
        nchk++; if (result_id !== IDW'(ex_id)) $display("FAIL fair_id[%0d]: got %0d expected %0d", c, result_id, ex_id); else npass++;
        nchk++; if (population !== 7'(ex_pop)) $display("FAIL fair_pop[%0d]: got %0d expected %0d", c, population, ex_pop); else npass++;
      end
    end
    nchk++; if (nres != 8) $display("FAIL fair_count: got %0d results expected 8", nres); else npass++;
  endtask

  task automatic test_boundary();
    logic [63:0] vals [4];
    int          exps [4];
    vals[0] = 64'hFFFF_FFFF_FFFF_FFFF; exps[0] = 64;
    vals[1] = 64'h0000_0000_0000_0000; exps[1] = 0;
    vals[2] = 64'h8000_0000_0000_0001; exps[2] = 2;
    vals[3] = 64'h5555_5555_5555_5555; exps[3] = 32;
    do_reset();
    for (int v = 0; v < 4; v++) begin
      req = 4'(1 << v);
      req_bb[v*64 +: 64] = vals[v];
      tick();
      req = '0;
      for (int c = 1; c < L; c++) tick();
      nchk++; if (result_valid !== 4'(1 << v)) $display("FAIL bound_rv[%0d]: got %b expected %b", v, result_valid, 4'(1 << v)); else npass++;
      nchk++; if (result_id !== 3'(v)) $display("FAIL bound_id[%0d]: got %0d expected %0d", v, result_id, v); else npass++;
      nchk++; if (population !== 7'(exps[v])) $display("FAIL bound_pop[%0d]: got %0d expected %0d", v, population, exps[v]); else npass++;
      tick();
    end
  endtask

  task automatic test_pointer_skip();
    do_reset();
    req = 4'b0001;
    req_bb[0 +: 64] = 64'h0000_0000_0000_000F;
    req_bb[3*64 +: 64] = 64'h0000_0000_0000_0F0F;
    tick();
    req = '0;
    for (int c = 0; c < L; c++) tick();
    req = 4'b1001;
    #1;
    nchk++; if (grant !== 4'b1000) $display("FAIL skip_grant3: got %b expected 1000", grant); else npass++;
    tick();
    req = 4'b0001;
    #1;
    nchk++; if (grant !== 4'b0001) $display("FAIL skip_grant0: got %b expected 0001", grant); else npass++;
    for (int c = 0; c < L + 1; c++) begin
      tick();
      req = '0;
      nchk++; if (result_valid !== ex_rv) $display("FAIL skip_rv[%0d]: got %b expected %b", c, result_valid, ex_rv); else npass++;
      if (ex_rv != 0) begin
        nchk++; if (result_id !== IDW'(ex_id)) $display("FAIL skip_id[%0d]: got %0d expected %0d", c, result_id, ex_id); else npass++;
        nchk++; if (population !== 7'(ex_pop)) $display("FAIL skip_pop[%0d]: got %0d expected %0d", c, population, ex_pop); else npass++;
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 300 + L; c++) begin
      req = (c < 300) ? 4'($urandom_range(0, 15)) : 4'b0000;
      for (int i = 0; i < NREQ; i++) begin
        case ($urandom_range(0, 3))
          0: req_bb[i*64 +: 64] = {$urandom, $urandom};
          1: req_bb[i*64 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
          2: req_bb[i*64 +: 64] = 64'h0;
          default: req_bb[i*64 +: 64] = (64'd1 << $urandom_range(0, 63)) | (64'd1 << $urandom_range(0, 63));
        endcase
      end
      #1;
      predict();
      nchk++; if (grant !== ex_grant) $display("FAIL rand_grant[%0d]: got %b expected %b", c, grant, ex_grant); else npass++;
      tick();
      nchk++; if (result_valid !== ex_rv) $display("FAIL rand_rv[%0d]: got %b expected %b", c, result_valid, ex_rv); else npass++;
      if (ex_rv != 0) begin
        nchk++; if (result_id !== IDW'(ex_id)) $display("FAIL rand_id[%0d]: got %0d expected %0d", c, result_id, ex_id); else npass++;
        nchk++; if (population !== 7'(ex_pop)) $display("FAIL rand_pop[%0d]: got %0d expected %0d", c, population, ex_pop); else npass++;
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 4'b0010;
    req_bb[64 +: 64] = 64'h0000_F0F0_0000_F0F0;
    #1;
    nchk++; if (grant !== 4'b0010) $display("FAIL midrst_grant: got %b expected 0010", grant); else npass++;
    tick();
    req = '0;
    reset = 1'b1;
    #1;
    nchk++; if (result_valid !== 4'b0000) $display("FAIL midrst_rv_in_reset: got %b expected 0000", result_valid); else npass++;
    tick();
    reset = 1'b0;
    for (int c = 0; c < L + 2; c++) begin
      #1;
      nchk++; if (result_valid !== 4'b0000) $display("FAIL midrst_rv[%0d]: got %b expected 0000", c, result_valid); else npass++;
      nchk++; if (result_id !== 3'd0) $display("FAIL midrst_id[%0d]: got %0d expected 0", c, result_id); else npass++;
      nchk++; if (population !== 7'd0) $display("FAIL midrst_pop[%0d]: got %0d expected 0", c, population); else npass++;
      tick();
    end
  endtask

  initial begin
    for (int k = 1; k <= L; k++) begin ep_v[k] = 0; ep_id[k] = 0; ep_pop[k] = 0; end
    test_reset();
    test_single();
    test_fairness();
    test_boundary();
    test_pointer_skip();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
